ibex_mult_pext_sequencer: RTL and testbench
===========================================

// Module: ibex_mult_pext_sequencer
// PURPOSE
//  Multi-cycle sequencer for the P-ext/M-ext multiplier path in the EX stage.
//  - Consumes the per-op control decoded upstream (cycle count, accumulate flag).
//  - Steps the multiplier through 1-3 cycles and buffers the intermediate partial
//    product between steps.
//  - Schedules the final ALU accumulate cycle, tracks sticky overflow and reports
//    completion to the EX block.
// PARAMETERS
//  IMD_W  34  width of intermediate-value buffer (partial product incl. carry bits)
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      async reset, active-high
//  mult_en_i      in   1      EX requests mult op; held high until valid_o
//  kill_i         in   1      flush (branch/exception); abort current op
//  cycle_count_i  in   2      00=1 cyc, 01=2 mult cyc, 10=mult+accum, 11=2 mult+accum
//  accum_i        in   1      op accumulates into rd via ALU (checked vs cycle_count_i)
//  imd_val_d_i    in   IMD_W  partial result from multiplier datapath
//  imd_val_we_i   in   1      multiplier requests capture of imd_val_d_i
//  ov_i           in   1      saturation/overflow from datapath this cycle
//  imd_val_q_o    out  IMD_W  buffered partial result fed back to datapath
//  mult_stage_o   out  2      0=MULT0, 1=MULT1, 2=ACCUM, 3=unused
//  alu_accum_o    out  1      ALU performs rd +/- result this cycle
//  valid_o        out  1      result valid this cycle; op complete
//  ov_o           out  1      overflow of completed op (qualified by valid_o)
//  busy_o         out  1      sequencer not in IDLE
// BEHAVIOUR
//  Reset (async, rst_i=1):
//  - state=IDLE, cc_q=00, imd_val_q_o=0, ov_q=0.
//  - All outputs 0.
//  State machine: IDLE, MULT1, ACCUM (enum in package); cc_q latched on IDLE start.
//  - IDLE, mult_en_i=1, cc=00: stage=0, valid_o=1 same cycle; stay IDLE.
//  - IDLE, mult_en_i=1, cc=01: stage=0, capture imd; go MULT1.
//  - IDLE, mult_en_i=1, cc=10: stage=0, capture imd; go ACCUM.
//  - IDLE, mult_en_i=1, cc=11: stage=0, capture imd; go MULT1.
//  - MULT1: stage=1. If cc_q=01: valid_o=1, go IDLE. If cc_q=11: capture imd, go ACCUM.
//  - ACCUM: stage=2, alu_accum_o=1, valid_o=1; go IDLE.
//  - Latency (start to valid_o): cc=00 -> 0 cycles, 01/10 -> 1 cycle, 11 -> 2 cycles.
//  - cycle_count_i and accum_i are ignored outside IDLE-start (latched in cc_q).
//  - accum_i=1 with cc in {00,01} is an illegal decode: assertion, no special RTL.
//  - mult_en_i low while not IDLE: illegal; assertion only, FSM continues.
//  - Back-to-back ops: mult_en_i still high in IDLE the cycle after valid_o starts
//    the next op (EX has advanced).
//  Intermediate buffer:
//  - imd_val_q <= imd_val_d_i when imd_val_we_i=1 and state is MULT0/MULT1 and kill_i=0.
//  - Held otherwise; not cleared at op end.
//  Overflow:
//  - ov_q is cleared on op start; otherwise ov_q |= ov_i each active cycle.
//  - ov_o = (ov_q | ov_i) & valid_o.
//  - cc=00: ov_o = ov_i & valid_o.
//  kill_i:
//  - Priority over all transitions: next state IDLE.
//  - valid_o=0, alu_accum_o=0, no imd capture, ov_q cleared.
//  - kill_i with mult_en_i in IDLE: op not started.
//  Mid-op reset: immediate return to reset values; no partial completion reported.
//  busy_o = (state != IDLE).
// STRUCTURE
//  - ibex_pkg_pext: mult_seq_state_e {IDLE, MULT1, ACCUM}.
//  - ibex_pkg_pext: mult_stage_e {MULT0=0, MULT1=1, ACCUM=2}.
//  - ibex_pkg_pext: cycle-count encoding constants (CC_1, CC_2, CC_1A, CC_2A).
//  - No sub-module: one FSM always_ff/always_comb pair plus two registers.
// TESTING
//  - cc=00, mult_en_i=1 one cycle -> valid_o=1 same cycle, stage=0, busy_o=0.
//  - cc=11, ov_i=1 only in MULT0 -> stages 0,1,2.
//    alu_accum_o=1 and valid_o=1 on cycle 3 only; ov_o=1 on that cycle.
//  - cc=01, imd_val_d_i=34'h2_DEAD_BEEF with we in MULT0 -> imd_val_q_o=34'h2_DEAD_BEEF
//    in MULT1; valid_o in MULT1.
//  - cc=10, kill_i=1 in ACCUM -> valid_o=0, alu_accum_o=0, IDLE next cycle, ov_q=0.
//  - rst_i pulse mid-MULT1 of cc=11 -> outputs 0 asynchronously; next op starts
//    cleanly from IDLE.
//  - Back-to-back: cc=10 then cc=00 with mult_en_i held -> valid_o on cycles 2 and 3,
//    no gap.

Source files
------------

// File: rtl/ibex_mult_pext_sequencer_pkg.sv
// Shared types and encodings for the P-ext/M-ext multiplier sequencer.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_MULT1 = 2'd1,
    SEQ_ACCUM = 2'd2
  } mult_seq_state_e;

  typedef enum logic [1:0] {
    STAGE_MULT0 = 2'd0,
    STAGE_MULT1 = 2'd1,
    STAGE_ACCUM = 2'd2
  } mult_stage_e;

  localparam logic [1:0] CC_1  = 2'b00;
  localparam logic [1:0] CC_2  = 2'b01;
  localparam logic [1:0] CC_1A = 2'b10;
  localparam logic [1:0] CC_2A = 2'b11;

  // Upper bit of the cycle-count encoding marks ops that finish with an ALU accumulate.
  function automatic logic cc_has_accum(input logic [1:0] cc);
    return cc[1];
  endfunction

endpackage

// File: rtl/ibex_mult_pext_sequencer_chk.sv
// Protocol checks on the sequencer's EX-side handshake (simulation only).
module ibex_mult_pext_sequencer_chk
  import ibex_pkg_pext::*;
(
  input logic       clk_i,
  input logic       rst_i,
  input logic       mult_en_i,
  input logic       kill_i,
  input logic [1:0] cycle_count_i,
  input logic       accum_i,
  input logic       busy_i
);

  // Decode consistency at op start and request stability while an op is in flight.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (mult_en_i && !busy_i && !kill_i) begin
        assert (!accum_i || cc_has_accum(cycle_count_i));
      end
      if (busy_i && !kill_i) begin
        assert (mult_en_i);
      end
    end
  end

endmodule

// File: rtl/ibex_mult_pext_sequencer.sv
// Multi-cycle sequencer for the EX-stage multiplier: steps MULT0/MULT1/ACCUM,
// buffers the partial product between steps and reports completion/overflow.
module ibex_mult_pext_sequencer
  import ibex_pkg_pext::*;
#(
  parameter int unsigned IMD_W = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mult_en_i,
  input  logic             kill_i,
  input  logic [1:0]       cycle_count_i,
  input  logic             accum_i,
  input  logic [IMD_W-1:0] imd_val_d_i,
  input  logic             imd_val_we_i,
  input  logic             ov_i,
  output logic [IMD_W-1:0] imd_val_q_o,
  output logic [1:0]       mult_stage_o,
  output logic             alu_accum_o,
  output logic             valid_o,
  output logic             ov_o,
  output logic             busy_o
);

  mult_seq_state_e  r_state;
  mult_seq_state_e  w_state_d;
  mult_stage_e      w_stage;
  logic [1:0]       r_cc_q;
  logic [IMD_W-1:0] r_imd_val_q;
  logic             r_ov_q;
  logic             w_ov_d;
  logic             w_start;
  logic             w_capture;
  logic             w_valid;
  logic             w_accum;
  logic             w_busy;

  assign w_busy = (r_state != SEQ_IDLE);

  // Next-state, stage and completion decode; kill_i overrides every transition.
  always_comb begin
    w_state_d = r_state;
    w_stage   = STAGE_MULT0;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_valid   = 1'b0;
    w_accum   = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (mult_en_i) begin
          w_start   = 1'b1;
          w_capture = imd_val_we_i;
          case (cycle_count_i)
            CC_1:    w_valid   = 1'b1;
            CC_2:    w_state_d = SEQ_MULT1;
            CC_1A:   w_state_d = SEQ_ACCUM;
            CC_2A:   w_state_d = SEQ_MULT1;
            default: w_state_d = SEQ_IDLE;
          endcase
        end else begin
          w_state_d = SEQ_IDLE;
        end
      end
      SEQ_MULT1: begin
        w_stage   = STAGE_MULT1;
        w_capture = imd_val_we_i;
        if (r_cc_q == CC_2A) begin
          w_state_d = SEQ_ACCUM;
        end else begin
          w_valid   = 1'b1;
          w_state_d = SEQ_IDLE;
        end
      end
      SEQ_ACCUM: begin
        w_stage   = STAGE_ACCUM;
        w_accum   = 1'b1;
        w_valid   = 1'b1;
        w_state_d = SEQ_IDLE;
      end
      default: begin
        w_state_d = SEQ_IDLE;
      end
    endcase
    if (kill_i) begin
      w_state_d = SEQ_IDLE;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_valid   = 1'b0;
      w_accum   = 1'b0;
    end else begin
      w_state_d = w_state_d;
    end
  end

  // Sticky overflow restarts with the first cycle's flag so stale ops never leak in.
  always_comb begin
    w_ov_d = r_ov_q;
    if (kill_i) begin
      w_ov_d = 1'b0;
    end else if (w_start) begin
      w_ov_d = ov_i;
    end else if (w_busy) begin
      w_ov_d = r_ov_q | ov_i;
    end else begin
      w_ov_d = r_ov_q;
    end
  end

  // State, latched cycle count and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SEQ_IDLE;
      r_cc_q  <= 2'b00;
      r_ov_q  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ov_q  <= w_ov_d;
      if (w_start) begin
        r_cc_q <= cycle_count_i;
      end
    end
  end

  // Partial-product buffer; deliberately kept across op boundaries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_imd_val_q <= '0;
    end else if (w_capture) begin
      r_imd_val_q <= imd_val_d_i;
    end
  end

  // Single-cycle ops complete combinationally, so outputs are masked during reset.
  assign imd_val_q_o  = r_imd_val_q;
  assign mult_stage_o = w_stage;
  assign busy_o       = w_busy;
  assign valid_o      = w_valid & ~rst_i;
  assign alu_accum_o  = w_accum & ~rst_i;
  assign ov_o         = ((r_ov_q & w_busy) | ov_i) & valid_o;

  ibex_mult_pext_sequencer_chk u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mult_en_i     (mult_en_i),
    .kill_i        (kill_i),
    .cycle_count_i (cycle_count_i),
    .accum_i       (accum_i),
    .busy_i        (w_busy)
  );

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// Self-checking bench: directed scenarios plus randomized ops against an op-level model.
module tb_ibex_mult_pext_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mult_en_i;
  logic        kill_i;
  logic [1:0]  cycle_count_i;
  logic        accum_i;
  logic [33:0] imd_val_d_i;
  logic        imd_val_we_i;
  logic        ov_i;
  logic [33:0] imd_val_q_o;
  logic [1:0]  mult_stage_o;
  logic        alu_accum_o;
  logic        valid_o;
  logic        ov_o;
  logic        busy_o;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] m_imd = 34'd0;

  always #5 clk = ~clk;

  ibex_mult_pext_sequencer #(.IMD_W(34)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mult_en_i     (mult_en_i),
    .kill_i        (kill_i),
    .cycle_count_i (cycle_count_i),
    .accum_i       (accum_i),
    .imd_val_d_i   (imd_val_d_i),
    .imd_val_we_i  (imd_val_we_i),
    .ov_i          (ov_i),
    .imd_val_q_o   (imd_val_q_o),
    .mult_stage_o  (mult_stage_o),
    .alu_accum_o   (alu_accum_o),
    .valid_o       (valid_o),
    .ov_o          (ov_o),
    .busy_o        (busy_o)
  );

  // Observed vector layout: {stage[1:0], valid, alu_accum, ov, busy}
  task automatic drive(input logic en, input logic k, input logic [1:0] c,
                       input logic o, input logic w, input logic [33:0] d);
    mult_en_i     = en;
    kill_i        = k;
    cycle_count_i = c;
    accum_i       = c[1];
    ov_i          = o;
    imd_val_we_i  = w;
    imd_val_d_i   = d;
  endtask

  task automatic tick(input logic cap);
    if (cap) m_imd = imd_val_d_i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 34'h3_FFFF_FFFF);
    m_imd = 34'd0;
    repeat (2) @(posedge clk);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b000000);
    end
    checks++;
    if (imd_val_q_o !== 34'd0) begin
      errors++;
      $display("FAIL reset_imd: got %h want %h", imd_val_q_o, 34'd0);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_cc00();
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 34'd0);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b001010) begin
      errors++;
      $display("FAIL cc00_single: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b001010);
    end
    tick(1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 34'd0);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b000000) begin
      errors++;
      $display("FAIL cc00_after: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b000000);
    end
    tick(1'b0);
  endtask

  task automatic test_cc11_ov();
    logic [5:0] exp_v [3];
    exp_v[0] = 6'b000000;
    exp_v[1] = 6'b010001;
    exp_v[2] = 6'b101111;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 2'b11, (j == 0), 1'b0, 34'd0);
      #4;
      checks++;
      if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== exp_v[j]) begin
        errors++;
        $display("FAIL cc11_cycle%0d: got %b want %b", j,
                 {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, exp_v[j]);
      end
      tick(1'b0);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    #4;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cc11_idle_busy: got %b want %b", busy_o, 1'b0);
    end
    tick(1'b0);
  endtask

  task automatic test_imd_capture();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 34'h2_DEAD_BEEF);
    #4;
    tick(1'b1);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 34'h1_2345_6789);
    #4;
    checks++;
    if (imd_val_q_o !== 34'h2_DEAD_BEEF) begin
      errors++;
      $display("FAIL imd_mult1: got %h want %h", imd_val_q_o, 34'h2_DEAD_BEEF);
    end
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b011001) begin
      errors++;
      $display("FAIL imd_mult1_ctl: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b011001);
    end
    tick(1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 34'h0_0000_0001);
    #4;
    checks++;
    if (imd_val_q_o !== 34'h2_DEAD_BEEF) begin
      errors++;
      $display("FAIL imd_hold_idle: got %h want %h", imd_val_q_o, 34'h2_DEAD_BEEF);
    end
    tick(1'b0);
  endtask

  task automatic test_kill();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 34'd0);
    #4;
    tick(1'b0);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 34'h0_AAAA_5555);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b100001) begin
      errors++;
      $display("FAIL kill_accum: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b100001);
    end
    tick(1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b000000) begin
      errors++;
      $display("FAIL kill_idle: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b000000);
    end
    tick(1'b0);
    // kill together with a start request: op must not begin
    drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 34'h1_1111_1111);
    #4;
    checks++;
    if ({valid_o, ov_o} !== 2'b00) begin
      errors++;
      $display("FAIL kill_start_valid: got %b want %b", {valid_o, ov_o}, 2'b00);
    end
    tick(1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    #4;
    checks++;
    if ({busy_o, imd_val_q_o} !== {1'b0, m_imd}) begin
      errors++;
      $display("FAIL kill_start_state: got %b/%h want %b/%h", busy_o, imd_val_q_o, 1'b0, m_imd);
    end
    tick(1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 34'h3_0F0F_0F0F);
    #4;
    tick(1'b1);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 34'd0);
    #2;
    rst_i = 1'b1;
    m_imd = 34'd0;
    #1;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o, imd_val_q_o} !== {6'b000000, m_imd}) begin
      errors++;
      $display("FAIL reset_mid: got %b/%h want %b/%h",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, imd_val_q_o, 6'b000000, m_imd);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 34'd0);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_restart0: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b000000);
    end
    tick(1'b0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 34'd0);
    #4;
    checks++;
    if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b011001) begin
      errors++;
      $display("FAIL reset_restart1: got %b want %b",
               {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b011001);
    end
    tick(1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    tick(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v [3];
    logic [1:0] cc_v  [3];
    exp_v[0] = 6'b000000; cc_v[0] = 2'b10;
    exp_v[1] = 6'b101101; cc_v[1] = 2'b00;
    exp_v[2] = 6'b001000; cc_v[2] = 2'b00;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, cc_v[j], 1'b0, 1'b0, 34'd0);
      #4;
      checks++;
      if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== exp_v[j]) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %b want %b", j,
                 {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, exp_v[j]);
      end
      tick(1'b0);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    tick(1'b0);
  endtask

  // Op-level model: an op of count cc lasts 1+cc[0]+cc[1] cycles, ends in ACCUM iff cc[1].
  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [1:0] c;
      int         len;
      int         kill_at;
      logic       ov_acc;
      logic       killed;
      c       = 2'($urandom_range(3, 0));
      len     = 1 + int'(c[0]) + int'(c[1]);
      kill_at = ($urandom_range(7, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
      ov_acc  = 1'b0;
      killed  = 1'b0;
      if ($urandom_range(1, 0) == 1) begin
        drive(1'b0, 1'b0, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b1, 34'h0_0BAD_F00D);
        #4;
        checks++;
        if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o, imd_val_q_o} !== {6'b000000, m_imd}) begin
          errors++;
          $display("FAIL rnd_gap op%0d: got %b/%h want %b/%h", n,
                   {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, imd_val_q_o, 6'b000000, m_imd);
        end
        tick(1'b0);
      end
      for (int j = 0; j < len; j++) begin
        logic        o, w, k, v, a;
        logic [1:0]  st;
        logic [63:0] r;
        logic [5:0]  exp_v;
        r  = {$urandom, $urandom};
        o  = ($urandom_range(3, 0) == 0);
        w  = 1'($urandom_range(1, 0));
        k  = (j == kill_at);
        drive(1'b1, k, (j == 0) ? c : 2'($urandom_range(3, 0)), o, w, r[33:0]);
        ov_acc = ov_acc | o;
        st = (j == 0) ? 2'd0 : ((j == len - 1 && c[1]) ? 2'd2 : 2'd1);
        v  = (j == len - 1) && !k;
        a  = v && c[1];
        exp_v = {st, v, a, v & ov_acc, (j > 0)};
        #4;
        checks++;
        if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== exp_v) begin
          errors++;
          $display("FAIL rnd_ctl op%0d cc%b cyc%0d: got %b want %b", n, c, j,
                   {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, exp_v);
        end
        checks++;
        if (imd_val_q_o !== m_imd) begin
          errors++;
          $display("FAIL rnd_imd op%0d cyc%0d: got %h want %h", n, j, imd_val_q_o, m_imd);
        end
        tick(w && !k && (st != 2'd2));
        if (k) begin
          killed = 1'b1;
          break;
        end
      end
      if (killed) begin
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
        #4;
        checks++;
        if ({mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o} !== 6'b000000) begin
          errors++;
          $display("FAIL rnd_after_kill op%0d: got %b want %b", n,
                   {mult_stage_o, valid_o, alu_accum_o, ov_o, busy_o}, 6'b000000);
        end
        tick(1'b0);
      end
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 34'd0);
    tick(1'b0);
  endtask

  initial begin
    test_reset();
    test_cc00();
    test_cc11_ov();
    test_imd_capture();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
